// File: rtl/alu_issue_ctrl.sv
// alu_issue_ctrl: issues one instruction at a time to an external clocked ALU
// and writes the registered result back to an 8x8 register file or to the
// condition bit.
//
// Ports:
//   clk_i, rst_n_i              clock, async active-low reset
//   instr_i/instr_valid_i       instruction {op[7:5], R[4:2], rsvd[1:0]}
//   instr_ready_o               high in IDLE only
//   alu_opcode_o/rs_o/rt_o      registered operands presented to the ALU
//   alu_result_i/set_i/zero_i   ALU result, set flag, equality flag
//   ext_we_i/addr_i/data_i      external register-file write port
//   dbg_addr_i/dbg_data_o       combinational register-file read port
//   cb_o                        condition bit
//   done_o                      one-cycle completion pulse (WRITEBACK)
module alu_issue_ctrl #(
   parameter int unsigned DATA_W = 8,
   parameter int unsigned RT_REG = 7
) (
   input  logic              clk_i,
   input  logic              rst_n_i,
   input  logic [7:0]        instr_i,
   input  logic              instr_valid_i,
   output logic              instr_ready_o,
   output logic [2:0]        alu_opcode_o,
   output logic [DATA_W-1:0] alu_rs_o,
   output logic [DATA_W-1:0] alu_rt_o,
   input  logic [DATA_W-1:0] alu_result_i,
   input  logic              alu_set_i,
   input  logic              alu_zero_i,
   input  logic              ext_we_i,
   input  logic [2:0]        ext_addr_i,
   input  logic [DATA_W-1:0] ext_data_i,
   input  logic [2:0]        dbg_addr_i,
   output logic [DATA_W-1:0] dbg_data_o,
   output logic              cb_o,
   output logic              done_o
);

   localparam int unsigned NUM_REGS = 8;
   localparam int unsigned ADDR_W   = 3;
   localparam logic [2:0]  OP_SLT   = 3'b101;
   localparam logic [2:0]  OP_SEQ   = 3'b111;

   typedef enum logic [1:0] {
      IDLE      = 2'd0,
      ISSUE     = 2'd1,
      WRITEBACK = 2'd2
   } state_t;

   state_t state, state_nx;

   logic [DATA_W-1:0] rf [NUM_REGS];
   logic [ADDR_W-1:0] r_q;
   logic              pend_cb;

   logic accept_c;
   logic wb_reg_we_c;
   logic wb_cb_set_c;
   logic wb_cb_seq_c;
   logic ext_commit_c;
   logic unused_instr_c;

   assign unused_instr_c = ^instr_i[1:0];

   // State register
   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) state <= IDLE;
      else          state <= state_nx;
   end

   // Next state and per-cycle control strobes
   always_comb begin
      state_nx     = state;
      accept_c     = 1'b0;
      wb_reg_we_c  = 1'b0;
      wb_cb_set_c  = 1'b0;
      wb_cb_seq_c  = 1'b0;
      case (state)
         IDLE: begin
            if (instr_valid_i) begin
               accept_c = 1'b1;
               state_nx = ISSUE;
            end
         end
         ISSUE: state_nx = WRITEBACK;
         WRITEBACK: begin
            state_nx    = IDLE;
            wb_cb_set_c = (alu_opcode_o == OP_SLT);
            wb_cb_seq_c = (alu_opcode_o == OP_SEQ);
            wb_reg_we_c = !wb_cb_set_c && !wb_cb_seq_c;
         end
         default: state_nx = IDLE;
      endcase
      // Writeback owns the port when both target the same register
      ext_commit_c = ext_we_i && !(wb_reg_we_c && (ext_addr_i == r_q));
   end

   assign instr_ready_o = (state == IDLE);
   assign done_o        = (state == WRITEBACK);
   assign dbg_data_o    = rf[dbg_addr_i];

   // Register file: external and writeback ports
   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         for (int i = 0; i < int'(NUM_REGS); i++) rf[i] <= '0;
      end else begin
         if (ext_commit_c) rf[ext_addr_i] <= ext_data_i;
         if (wb_reg_we_c)  rf[r_q]        <= alu_result_i;
      end
   end

   // Operand capture at acceptance; held until the next acceptance
   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         alu_opcode_o <= '0;
         alu_rs_o     <= '0;
         alu_rt_o     <= '0;
         r_q          <= '0;
      end else if (accept_c) begin
         alu_opcode_o <= instr_i[7:5];
         r_q          <= instr_i[4:2];
         alu_rs_o     <= rf[instr_i[4:2]];
         alu_rt_o     <= rf[ADDR_W'(RT_REG)];
      end
   end

   // Condition bit; seq captures the combinational equality while operands
   // are still at the ALU, then commits it with the writeback
   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         pend_cb <= 1'b0;
         cb_o    <= 1'b0;
      end else begin
         if (state == ISSUE && alu_opcode_o == OP_SEQ) pend_cb <= alu_zero_i;
         if (wb_cb_set_c)      cb_o <= alu_set_i;
         else if (wb_cb_seq_c) cb_o <= pend_cb;
      end
   end

endmodule
